// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a single
// memory port; one transaction outstanding at a time.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              areset,

   input  logic              i_req_valid,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_req_ready,
   output logic              i_rsp_valid,
   output logic [DATA_W-1:0] i_rsp_data,

   input  logic              d_req_valid,
   input  logic              d_req_write,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,

   output logic              m_req_valid,
   output logic              m_req_write,
   output logic [ADDR_W-1:0] m_req_addr,
   output logic [DATA_W-1:0] m_req_wdata,
   input  logic              m_req_ready,
   input  logic              m_rsp_valid,
   input  logic [DATA_W-1:0] m_rsp_data,

   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   logic   last_d;    // 1 when the data port holds the most recent grant
   logic   grant_d;   // port owning the outstanding transaction
   logic   pick_d;

   // NOTE: every output of this block is assigned on every path, so no latch is inferred.
   always_comb begin
      pick_d      = d_req_valid && (!i_req_valid || !last_d);
      i_req_ready = (state == IDLE) && i_req_valid && !pick_d;
      d_req_ready = (state == IDLE) && pick_d;
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge areset) begin
      if (!areset) begin
         state       <= IDLE;
         last_d      <= 1'b1;
         grant_d     <= 1'b0;
         m_req_valid <= 1'b0;
         m_req_write <= 1'b0;
         m_req_addr  <= '0;
         m_req_wdata <= '0;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         i_rsp_data  <= '0;
         d_rsp_data  <= '0;
         busy        <= 1'b0;
      end else begin
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_ready || d_req_ready) begin
                  grant_d     <= pick_d;
                  last_d      <= pick_d;
                  m_req_valid <= 1'b1;
                  m_req_write <= pick_d && d_req_write;
                  m_req_addr  <= pick_d ? d_req_addr : i_req_addr;
                  m_req_wdata <= pick_d ? d_req_wdata : '0;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_req_ready) begin
                  m_req_valid <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               // Write acks return no data to the requester.
               if (m_rsp_valid) begin
                  if (grant_d) begin
                     d_rsp_valid <= 1'b1;
                     d_rsp_data  <= m_req_write ? '0 : m_rsp_data;
                  end else begin
                     i_rsp_valid <= 1'b1;
                     i_rsp_data  <= m_rsp_data;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               m_req_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          areset = 1'b0;
   logic          i_req_valid = 1'b0;
   logic [AW-1:0] i_req_addr = '0;
   logic          i_req_ready;
   logic          i_rsp_valid;
   logic [DW-1:0] i_rsp_data;
   logic          d_req_valid = 1'b0;
   logic          d_req_write = 1'b0;
   logic [AW-1:0] d_req_addr = '0;
   logic [DW-1:0] d_req_wdata = '0;
   logic          d_req_ready;
   logic          d_rsp_valid;
   logic [DW-1:0] d_rsp_data;
   logic          m_req_valid;
   logic          m_req_write;
   logic [AW-1:0] m_req_addr;
   logic [DW-1:0] m_req_wdata;
   logic          m_req_ready = 1'b0;
   logic          m_rsp_valid = 1'b0;
   logic [DW-1:0] m_rsp_data = '0;
   logic          busy;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .areset(areset),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
      .m_req_wdata(m_req_wdata), .m_req_ready(m_req_ready),
      .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
      .busy(busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic probe();
      @(negedge clock);
   endtask

   // Memory side: scripted by the main sequence or randomized.
   int            mem_mode = 1;
   logic          man_ready = 1'b0;
   logic          man_rsp = 1'b0;
   logic [DW-1:0] man_data = '0;

   always @(posedge clock) begin
      #2;
      if (mem_mode == 1) begin
         m_req_ready = man_ready;
         m_rsp_valid = man_rsp;
         m_rsp_data  = man_data;
      end else begin
         m_req_ready = ($urandom_range(0, 2) != 0);
         m_rsp_valid = ($urandom_range(0, 2) == 0);
         m_rsp_data  = $urandom;
      end
   end

   int hs_count = 0;
   always @(negedge clock) if (areset && m_req_valid && m_req_ready) hs_count++;

   // Transaction-level reference model.
   typedef struct packed {
      logic          port;   // 0 = fetch, 1 = data
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } rsp_t;

   txn_t          txn_q[$];
   rsp_t          rsp_q[$];
   bit            accepted = 1'b0;
   bit            last_port = 1'b1;
   logic [DW-1:0] hold_i = '0;
   logic [DW-1:0] hold_d = '0;

   always @(negedge clock) begin : model
      bit   free, gi, gd, exp_iv, exp_dv;
      txn_t t;
      rsp_t r;
      if (!areset) begin
         txn_q.delete();
         rsp_q.delete();
         accepted  = 1'b0;
         last_port = 1'b1;
         hold_i    = '0;
         hold_d    = '0;
      end
      free = (txn_q.size() == 0);
      gi = 1'b0;
      gd = 1'b0;
      if (free) begin
         if (i_req_valid && d_req_valid) begin
            if (last_port) gi = 1'b1;
            else           gd = 1'b1;
         end else begin
            gi = i_req_valid;
            gd = d_req_valid;
         end
      end
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (rsp_q.size() != 0) begin
         exp_iv = !rsp_q[0].port;
         exp_dv = rsp_q[0].port;
      end
      check("model_i_req_ready", i_req_ready, gi);
      check("model_d_req_ready", d_req_ready, gd);
      check("model_busy", busy, !free);
      check("model_m_req_valid", m_req_valid, !free && !accepted);
      if (!free && !accepted) begin
         check("model_m_req_write", m_req_write, txn_q[0].write);
         check("model_m_req_addr", m_req_addr, txn_q[0].addr);
         check("model_m_req_wdata", m_req_wdata, txn_q[0].wdata);
      end
      check("model_i_rsp_valid", i_rsp_valid, exp_iv);
      check("model_d_rsp_valid", d_rsp_valid, exp_dv);
      check("model_i_rsp_data", i_rsp_data, hold_i);
      check("model_d_rsp_data", d_rsp_data, hold_d);

      if (areset) begin
         if (rsp_q.size() != 0) void'(rsp_q.pop_front());
         if (!free && accepted && m_rsp_valid) begin
            r.port = txn_q[0].port;
            r.data = txn_q[0].write ? '0 : m_rsp_data;
            rsp_q.push_back(r);
            if (r.port) hold_d = r.data;
            else        hold_i = r.data;
            void'(txn_q.pop_front());
            accepted = 1'b0;
         end else if (!free && !accepted && m_req_ready) begin
            accepted = 1'b1;
         end
         if (gi || gd) begin
            t.port  = gd;
            t.write = gd && d_req_write;
            t.addr  = gd ? d_req_addr : i_req_addr;
            t.wdata = gd ? d_req_wdata : '0;
            txn_q.push_back(t);
            last_port = gd;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_base;
      int n;
      int cyc;

      // Reset state
      repeat (3) step();
      probe();
      check("rst_m_req_valid", m_req_valid, 0);
      check("rst_m_req_write", m_req_write, 0);
      check("rst_m_req_addr", m_req_addr, 0);
      check("rst_m_req_wdata", m_req_wdata, 0);
      check("rst_i_rsp_valid", i_rsp_valid, 0);
      check("rst_d_rsp_valid", d_rsp_valid, 0);
      check("rst_i_rsp_data", i_rsp_data, 0);
      check("rst_d_rsp_data", d_rsp_data, 0);
      check("rst_busy", busy, 0);

      // Post-reset conflict: fetch first, data re-arbitrated on the response cycle
      step(); areset = 1'b1;
      i_req_valid = 1'b1; i_req_addr = 32'h100;
      d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_write = 1'b0;
      probe();
      check("conflict_i_ready", i_req_ready, 1);
      check("conflict_d_ready", d_req_ready, 0);
      step(); i_req_valid = 1'b0; man_ready = 1'b1;
      probe();
      check("conflict_m_valid", m_req_valid, 1);
      check("conflict_m_addr_i", m_req_addr, 32'h100);
      check("conflict_d_ready_issue", d_req_ready, 0);
      step(); man_ready = 1'b0; man_rsp = 1'b1; man_data = 32'hAAAA0001;
      probe();
      check("conflict_busy_wait", busy, 1);
      step(); man_rsp = 1'b0;
      probe();
      check("conflict_i_rsp_valid", i_rsp_valid, 1);
      check("conflict_i_rsp_data", i_rsp_data, 32'hAAAA0001);
      check("conflict_d_ready_rearb", d_req_ready, 1);
      step(); d_req_valid = 1'b0; man_ready = 1'b1;
      probe();
      check("conflict_m_addr_d", m_req_addr, 32'h200);
      check("conflict_m_valid_d", m_req_valid, 1);
      step(); man_ready = 1'b0; man_rsp = 1'b1; man_data = 32'hBBBB0002;
      probe();
      step(); man_rsp = 1'b0;
      probe();
      check("conflict_d_rsp_valid", d_rsp_valid, 1);
      check("conflict_d_rsp_data", d_rsp_data, 32'hBBBB0002);
      check("conflict_i_rsp_quiet", i_rsp_valid, 0);

      // Spurious response in IDLE
      step(); man_rsp = 1'b1; man_data = 32'h1234;
      probe();
      for (int k = 0; k < 2; k++) begin
         step();
         if (k == 1) man_rsp = 1'b0;
         probe();
         check("spur_i_rsp_valid", i_rsp_valid, 0);
         check("spur_d_rsp_valid", d_rsp_valid, 0);
         check("spur_i_rsp_data", i_rsp_data, 32'hAAAA0001);
         check("spur_d_rsp_data", d_rsp_data, 32'hBBBB0002);
         check("spur_busy", busy, 0);
      end

      // Store with a five-cycle memory stall
      step();
      d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'hDEADBEEF;
      probe();
      check("store_d_ready", d_req_ready, 1);
      step(); d_req_valid = 1'b0; d_req_write = 1'b0; d_req_wdata = '0;
      hs_base = hs_count;
      for (int k = 0; k < 5; k++) begin
         probe();
         check("stall_m_valid", m_req_valid, 1);
         check("stall_m_write", m_req_write, 1);
         check("stall_m_addr", m_req_addr, 32'h40);
         check("stall_m_wdata", m_req_wdata, 32'hDEADBEEF);
         step();
      end
      man_ready = 1'b1;
      probe();
      step(); man_ready = 1'b0; man_rsp = 1'b1; man_data = 32'hFFFFFFFF;
      probe();
      check("stall_m_valid_done", m_req_valid, 0);
      check("stall_one_handshake", hs_count - hs_base, 1);
      step(); man_rsp = 1'b0;
      probe();
      check("store_d_rsp_valid", d_rsp_valid, 1);
      check("store_d_rsp_data_zero", d_rsp_data, 0);
      step();
      probe();
      check("store_single_pulse", d_rsp_valid, 0);
      check("stall_no_reissue", hs_count - hs_base, 1);

      // Fairness: both ports held valid for eight grants
      step();
      i_req_valid = 1'b1; i_req_addr = 32'h1000;
      d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_write = 1'b0;
      man_ready = 1'b1; man_rsp = 1'b1; man_data = 32'h5A5A;
      n = 0;
      cyc = 0;
      while (n < 8 && cyc < 100) begin
         probe();
         if (i_req_ready || d_req_ready) begin
            check($sformatf("fair_grant%0d_d", n), d_req_ready, (n % 2) == 1);
            check($sformatf("fair_grant%0d_i", n), i_req_ready, (n % 2) == 0);
            n++;
         end
         step();
         cyc++;
      end
      check("fair_grant_count", n, 8);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      repeat (4) step();
      man_ready = 1'b0; man_rsp = 1'b0;

      // Reset while waiting for the response
      step(); i_req_valid = 1'b1; i_req_addr = 32'h500;
      probe();
      check("rstwait_i_ready", i_req_ready, 1);
      step(); i_req_valid = 1'b0; man_ready = 1'b1;
      probe();
      step(); man_ready = 1'b0;
      probe();
      check("rstwait_busy_before", busy, 1);
      step(); areset = 1'b0;
      probe();
      check("rstwait_busy_in_reset", busy, 0);
      check("rstwait_m_valid_in_reset", m_req_valid, 0);
      step(); areset = 1'b1; man_rsp = 1'b1; man_data = 32'h7777;
      for (int k = 0; k < 3; k++) begin
         probe();
         check("rstwait_i_rsp_valid", i_rsp_valid, 0);
         check("rstwait_d_rsp_valid", d_rsp_valid, 0);
         check("rstwait_busy", busy, 0);
         check("rstwait_i_rsp_data", i_rsp_data, 0);
         step();
      end
      man_rsp = 1'b0;

      // Randomized traffic, random memory timing and occasional resets
      mem_mode = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!areset) areset = 1'b1;
         else if ($urandom_range(0, 399) == 0) areset = 1'b0;
         i_req_valid = ($urandom_range(0, 2) != 0);
         i_req_addr  = $urandom;
         d_req_valid = ($urandom_range(0, 2) != 0);
         d_req_write = $urandom_range(0, 1);
         d_req_addr  = $urandom;
         d_req_wdata = $urandom;
      end
      step();
      probe();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 areset  in  1  asynchronous, active-low reset; low SHALL force reset state immediately, independent of clock.
REQ-005 i_req_valid  in  1  instruction-fetch read request.
REQ-006 i_req_addr  in  ADDR_W  fetch address.
REQ-007 i_req_ready  out  1  fetch request accepted this cycle.
REQ-008 i_rsp_valid  out  1  one-cycle pulse: fetch data valid.
REQ-009 i_rsp_data  out  DATA_W  fetch read data.
REQ-010 d_req_valid  in  1  data-port request.
REQ-011 d_req_write  in  1  1 = store, 0 = load.
REQ-012 d_req_addr  in  ADDR_W  data address.
REQ-013 d_req_wdata  in  DATA_W  store data.
REQ-014 d_req_ready  out  1  data request accepted this cycle.
REQ-015 d_rsp_valid  out  1  one-cycle pulse: load data valid or store complete.
REQ-016 d_rsp_data  out  DATA_W  load data; all zeros for stores.
REQ-017 m_req_valid / m_req_write / m_req_addr / m_req_wdata  out  1/1/ADDR_W/DATA_W  shared memory request.
REQ-018 m_req_ready  in  1  memory accepts request.
REQ-019 m_rsp_valid / m_rsp_data  in  1/DATA_W  memory response (read data or write ack).
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT; at most one memory transaction SHALL be outstanding.
REQ-022 IDLE: if any *_req_valid is high, grant one port; assert its *_req_ready combinationally in that cycle only; latch addr/write/wdata (fetch: write=0, wdata=0) and grant id; go to ISSUE.
REQ-023 Arbitration SHALL be round-robin: on conflict, grant the port not granted last; a lone requester is always granted.
REQ-024 *_req_ready SHALL be low in ISSUE and WAIT, and never high for both ports in one cycle.
REQ-025 ISSUE: m_req_valid=1 with latched fields held stable until the cycle m_req_ready=1; then go to WAIT.
REQ-026 m_req_valid SHALL first assert the cycle after acceptance (one-cycle issue latency).
REQ-027 WAIT: on m_rsp_valid=1, register m_rsp_data (zero for writes) into the granted port's rsp_data, pulse its rsp_valid the next cycle, return to IDLE.
REQ-028 m_rsp_valid in IDLE or ISSUE SHALL be ignored, with no state or output change.
REQ-029 Re-arbitration SHALL occur in the same cycle the response pulse is driven (back-to-back grant possible).
REQ-030 Ungranted port's rsp_valid SHALL stay 0; rsp_data SHALL hold its last value between pulses.
REQ-031 Minimum round trip with m_req_ready and m_rsp_valid each returned one cycle after request: accept at cycle 0, m_req_valid cycles 1, m_rsp_valid cycle 2, rsp_valid cycle 3.

Reset
REQ-032 On areset low: state=IDLE, m_req_valid=0, m_req_write=0, m_req_addr=0, m_req_wdata=0, i_rsp_valid=0, d_rsp_valid=0, i_rsp_data=0, d_rsp_data=0, busy=0.
REQ-033 Last-grant SHALL reset to data port, so the fetch port wins the first conflict.
REQ-034 Reset mid-transaction SHALL drop the transaction with no response pulse; any late m_rsp_valid SHALL be ignored per REQ-028.

Verification
REQ-035 Post-reset conflict: both valid, i_addr=0x100, d_addr=0x200 load -> fetch granted first (m_req_addr=0x100), then data (0x200) on the response cycle.
REQ-036 Stall: m_req_ready low 5 cycles -> m_req_valid/addr/wdata stable all 5 cycles; exactly one transaction issued.
REQ-037 Store: d_req_write=1, addr=0x40, wdata=0xDEADBEEF -> m_req_write=1 with same addr/data; d_rsp_valid one pulse with d_rsp_data=0.
REQ-038 Fairness: both ports held valid for 8 transactions -> grants strictly alternate I,D,I,D,...
REQ-039 Reset in WAIT: areset low then high, then m_rsp_valid pulses -> no rsp_valid on either port; busy=0.
REQ-040 Spurious response: m_rsp_valid=1 in IDLE with data 0x1234 -> no rsp_valid, rsp_data unchanged.
